fp_mul_product_pipe: RTL and testbench
======================================

// Module: fp_mul_product_pipe
// PURPOSE
//  Front half of the pipelined FP32 multiplier in the inverse-square-root datapath. Operands are sign-less, positive only.
//  Unpacks two 31-bit floats {exp[30:23], frac[22:0]} and forms the 48-bit product of the mantissas, implicit 1 included.
//  Also forms the signed unbiased exponent sum. Feeds the normalise/round correction stage directly downstream.
//  float_in_2 and error_in are carried alongside, aligned with the data.
// PARAMETERS
//  END   0   0: error_in passes through unchanged and E_out_mul is truncated to 8 bits.
//            1: also raises error_out on a bad operand or exponent out of range.
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  valid        in   1   input strobe, one transaction per cycle when high
//  float_in_a   in   31  operand A {exp, frac}
//  float_in_b   in   31  operand B {exp, frac}
//  float_in_2   in   31  side operand, forwarded unchanged
//  error_in     in   1   upstream error flag
//  M_out_mul    out  48  {1,frac_a} * {1,frac_b}, bit 47 or bit 46 is the leading one
//  E_out_mul    out  8   signed (exp_a-127)+(exp_b-127)
//  float_out_2  out  31  float_in_2 delayed to match M_out_mul
//  ready        out  1   one-cycle pulse: outputs valid this cycle
//  error_out    out  1   error flag aligned with ready
// BEHAVIOUR
//  - Reset: async, while rst_n=0 all outputs are 0 and both internal valid bits (v1, v2) are 0.
//    Transactions in flight at reset are discarded and no ready is produced for them.
//  - Pipeline: 2 stages, latency 2 (valid at edge n -> ready high after edge n+2).
//    Throughput 1 per cycle. No backpressure: downstream always accepts.
//  - Stage 1, captured on the edge where valid=1; v1<=valid every cycle:
//    - ma={1,frac_a}, mb={1,frac_b}.
//    - p_lo = ma*mb[11:0] (36b); p_hi = ma*mb[23:12] (36b).
//    - es = 10-bit signed (exp_a-127)+(exp_b-127).
//    - bad = (exp_a==0)|(exp_a==255)|(exp_b==0)|(exp_b==255).
//    - float_in_2 and error_in are registered alongside.
//  - Stage 2, captured when v1=1; v2<=v1, and ready=v2:
//    - M_out_mul = p_lo + (p_hi<<12), exact, no truncation.
//    - E_out_mul = es[7:0].
//    - error_out, END=0: error_in (registered).
//    - error_out, END=1: error_in | bad | (es>126) | (es<-126).
//      The +126 limit leaves headroom for the downstream +1 normalise.
//  - When a stage's valid bit is 0, its data registers hold their previous value.
//    ready=0 in that case; error_out is forced to 0 when ready=0.
//  - Simultaneous events: a new valid while the previous transaction is in stage 2 is normal operation.
//    The two transactions do not interfere.
//  - Bit 47 of M_out_mul is set only when the product is >= 2.0. This stage performs no normalisation.
// TESTING
//  1) a=0x3F800000, b=0x3F800000, valid 1 cycle
//     -> ready 2 cycles later, M=48'h4000_0000_0000, E=0, error_out=0.
//  2) a=0x3FC00000 (1.5), b=0x40000000 (2.0)
//     -> M=48'h6000_0000_0000, E=1, float_out_2 equals float_in_2.
//  3) a=b=0x3FFFFFFF -> M=48'hFFFF_FE00_0001, E=0 (bit 47 set).
//  4) END=1: a=0x00000000 -> error_out=1 with ready.
//     END=1: a=b=0x7F000000 (es=254) -> error_out=1.
//     END=0: same inputs -> error_out=error_in.
//  5) Three back-to-back valids with distinct operands
//     -> three consecutive ready pulses, in order, each with the correct M/E.
//  6) Assert rst_n=0 one cycle after valid
//     -> all outputs 0 immediately and no ready pulse.
//     The first valid after release behaves as test 1.

Source files
------------

// File: rtl/fp_mul_product_pipe.sv
// fp_mul_product_pipe
// Front half of the pipelined FP32 multiplier. Unpacks two positive
// {exp[30:23], frac[22:0]} operands, forms the exact 48-bit mantissa product
// (implicit one included) and the signed unbiased exponent sum. It also
// carries a side operand and an error flag alongside the data.
//
// Handshake: valid marks one transaction in the current cycle. There is no
// backpressure, so every transaction is accepted. Two cycles after the cycle
// in which valid was high, ready pulses for exactly one cycle. The data
// outputs and error_out belong to that transaction while ready is high. When
// ready is low, the data outputs hold their last value and error_out reads 0.
module fp_mul_product_pipe #(
  parameter bit END = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [30:0] float_in_a,
  input  logic [30:0] float_in_b,
  input  logic [30:0] float_in_2,
  input  logic        error_in,
  output logic [47:0] M_out_mul,
  output logic [7:0]  E_out_mul,
  output logic [30:0] float_out_2,
  output logic        ready,
  output logic        error_out
);

  // Operand unpacking
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [23:0] ma;
  logic [23:0] mb;

  assign exp_a = float_in_a[30:23];
  assign exp_b = float_in_b[30:23];
  assign ma    = {1'b1, float_in_a[22:0]};
  assign mb    = {1'b1, float_in_b[22:0]};

  // Stage 1 combinational terms: two 24x12 partial products and exponent sum
  logic [35:0]        p_lo_d;
  logic [35:0]        p_hi_d;
  logic signed [9:0]  es_d;
  logic               bad_d;

  assign p_lo_d = 36'(ma) * 36'(mb[11:0]);
  assign p_hi_d = 36'(ma) * 36'(mb[23:12]);
  // Range of the sum is -254..+256, which fits a 10-bit signed value.
  assign es_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd254;
  assign bad_d  = (exp_a == 8'd0) | (exp_a == 8'hFF) |
                  (exp_b == 8'd0) | (exp_b == 8'hFF);

  // Stage 1 registers
  logic               v1;
  logic [35:0]        p_lo_r;
  logic [35:0]        p_hi_r;
  logic signed [9:0]  es_r;
  logic               bad_r;
  logic [30:0]        f2_r1;
  logic               err_r1;

  // Stage 1: capture partial products and side data when valid is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      p_lo_r <= '0;
      p_hi_r <= '0;
      es_r   <= '0;
      bad_r  <= 1'b0;
      f2_r1  <= '0;
      err_r1 <= 1'b0;
    end else begin
      v1 <= valid;
      if (valid) begin
        p_lo_r <= p_lo_d;
        p_hi_r <= p_hi_d;
        es_r   <= es_d;
        bad_r  <= bad_d;
        f2_r1  <= float_in_2;
        err_r1 <= error_in;
      end
    end
  end

  // Stage 2 combinational terms: recombine partial products, error policy
  logic [47:0] m_d;
  logic        range_bad;
  logic        err_d;

  // The product of two 24-bit mantissas is below 2^48, so the sum cannot
  // overflow the 48-bit result.
  assign m_d       = {12'd0, p_lo_r} + {p_hi_r, 12'd0};
  // +126 leaves room for the +1 applied when the downstream stage normalises.
  assign range_bad = (es_r > 10'sd126) | (es_r < -10'sd126);
  assign err_d     = END ? (err_r1 | bad_r | range_bad) : err_r1;

  // Stage 2 registers
  logic        v2;
  logic [47:0] m_r;
  logic [7:0]  e_r;
  logic [30:0] f2_r2;
  logic        err_r2;

  // Stage 2: capture the finished product when stage 1 holds a transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      m_r    <= '0;
      e_r    <= '0;
      f2_r2  <= '0;
      err_r2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        m_r    <= m_d;
        e_r    <= es_r[7:0];
        f2_r2  <= f2_r1;
        err_r2 <= err_d;
      end
    end
  end

  assign M_out_mul   = m_r;
  assign E_out_mul   = e_r;
  assign float_out_2 = f2_r2;
  assign ready       = v2;
  assign error_out   = v2 & err_r2;

endmodule

// File: tb/tb_fp_mul_product_pipe.sv
// Bench for fp_mul_product_pipe: two instances (END=0 and END=1) share the
// same stimulus; a behavioural model predicts each transaction and a compare
// process checks both instances on every falling edge.
module tb_fp_mul_product_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [30:0] float_in_a;
  logic [30:0] float_in_b;
  logic [30:0] float_in_2;
  logic        error_in;

  logic [47:0] m0, m1;
  logic [7:0]  e0, e1;
  logic [30:0] f20, f21;
  logic        rdy0, rdy1;
  logic        err0, err1;

  fp_mul_product_pipe #(.END(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .float_in_a(float_in_a), .float_in_b(float_in_b),
    .float_in_2(float_in_2), .error_in(error_in),
    .M_out_mul(m0), .E_out_mul(e0), .float_out_2(f20),
    .ready(rdy0), .error_out(err0)
  );

  fp_mul_product_pipe #(.END(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .float_in_a(float_in_a), .float_in_b(float_in_b),
    .float_in_2(float_in_2), .error_in(error_in),
    .M_out_mul(m1), .E_out_mul(e1), .float_out_2(f21),
    .ready(rdy1), .error_out(err1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic [47:0] m;
    logic [7:0]  e;
    logic [30:0] f2;
    logic        er0;
    logic        er1;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Reference: real-number meaning of the fields, computed with plain arithmetic.
  function automatic exp_t model(input logic [30:0] a, input logic [30:0] b,
                                 input logic [30:0] f2, input logic ein, input int due);
    exp_t        r;
    longint      ma, mb, prod;
    int          ea, eb, es;
    logic        bad;
    logic [31:0] es_bits;
    ma   = 64'h80_0000 + longint'(a[22:0]);
    mb   = 64'h80_0000 + longint'(b[22:0]);
    prod = ma * mb;
    ea   = int'(a[30:23]) - 127;
    eb   = int'(b[30:23]) - 127;
    es   = ea + eb;
    es_bits = es;
    bad  = (a[30:23] == 0) || (a[30:23] == 255) || (b[30:23] == 0) || (b[30:23] == 255);
    r.due = due;
    r.m   = prod[47:0];
    r.e   = es_bits[7:0];
    r.f2  = f2;
    r.er0 = ein;
    r.er1 = ein || bad || (es > 126) || (es < -126);
    return r;
  endfunction

  logic [47:0] last_m;
  logic [7:0]  last_e;
  logic [30:0] last_f2;

  // Compare process: one check set per falling edge
  always @(negedge clk) begin
    exp_t cur;
    logic exp_rdy;
    logic exp_e0, exp_e1;
    if (!rst_n) begin
      check("reset_outs_end0", {rdy0, err0, m0, e0, f20}, 64'd0);
      check("reset_outs_end1", {rdy1, err1, m1, e1, f21}, 64'd0);
      exp_q.delete();
      last_m  = '0;
      last_e  = '0;
      last_f2 = '0;
    end else begin
      exp_rdy = 1'b0;
      exp_e0  = 1'b0;
      exp_e1  = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cur     = exp_q.pop_front();
        exp_rdy = 1'b1;
        exp_e0  = cur.er0;
        exp_e1  = cur.er1;
        last_m  = cur.m;
        last_e  = cur.e;
        last_f2 = cur.f2;
      end
      check("ready_end0", 64'(rdy0), 64'(exp_rdy));
      check("ready_end1", 64'(rdy1), 64'(exp_rdy));
      check("mant_end0",  64'(m0),   64'(last_m));
      check("mant_end1",  64'(m1),   64'(last_m));
      check("exp_end0",   64'(e0),   64'(last_e));
      check("exp_end1",   64'(e1),   64'(last_e));
      check("f2_end0",    64'(f20),  64'(last_f2));
      check("f2_end1",    64'(f21),  64'(last_f2));
      check("err_end0",   64'(err0), 64'(exp_e0));
      check("err_end1",   64'(err1), 64'(exp_e1));
      if (valid)
        exp_q.push_back(model(float_in_a, float_in_b, float_in_2, error_in, cyc + 2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [30:0] a, input logic [30:0] b,
                      input logic [30:0] f2, input logic ein);
    valid      = 1'b1;
    float_in_a = a;
    float_in_b = b;
    float_in_2 = f2;
    error_in   = ein;
    @(posedge clk); #1;
    valid      = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 9))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'($urandom_range(189, 192));
      3:       return 8'($urandom_range(62, 65));
      default: return 8'($urandom_range(1, 254));
    endcase
  endfunction

  function automatic logic [30:0] rand_op();
    logic [22:0] fr;
    fr = 23'($urandom());
    return {rand_exp(), fr};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    exp_t pin;
    rst_n      = 1'b0;
    valid      = 1'b0;
    float_in_a = '0;
    float_in_b = '0;
    float_in_2 = '0;
    error_in   = 1'b0;

    // Hand-computed values that pin the model
    pin = model(31'h3F800000, 31'h3F800000, 31'h0, 1'b0, 0);
    check("pin_one_m", 64'(pin.m), 64'h4000_0000_0000);
    check("pin_one_e", 64'(pin.e), 64'h0);
    pin = model(31'h3FC00000, 31'h40000000, 31'h0, 1'b0, 0);
    check("pin_3_m", 64'(pin.m), 64'h6000_0000_0000);
    check("pin_3_e", 64'(pin.e), 64'h1);
    pin = model(31'h3FFFFFFF, 31'h3FFFFFFF, 31'h0, 1'b0, 0);
    check("pin_max_m", 64'(pin.m), 64'hFFFF_FE00_0001);
    pin = model(31'h7F000000, 31'h7F000000, 31'h0, 1'b0, 0);
    check("pin_big_err", {62'd0, pin.er1, pin.er0}, 64'd2);
    check("pin_big_e", 64'(pin.e), 64'hFE);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed cases
    send(31'h3F800000, 31'h3F800000, 31'h1234567, 1'b0); idle(3);
    send(31'h3FC00000, 31'h40000000, 31'h7ABCDEF, 1'b0); idle(3);
    send(31'h3FFFFFFF, 31'h3FFFFFFF, 31'h0000001, 1'b0); idle(3);
    send(31'h00000000, 31'h3F800000, 31'h0, 1'b0);        idle(3);
    send(31'h7F000000, 31'h7F000000, 31'h0, 1'b0);        idle(3);
    send(31'h7F000000, 31'h7F000000, 31'h0, 1'b1);        idle(3);
    // Exponent range edges: sums of 126 / 127 / -126 / -127
    send({8'd190, 23'h0}, {8'd190, 23'h1}, 31'h11, 1'b0);
    send({8'd190, 23'h2}, {8'd191, 23'h3}, 31'h22, 1'b0);
    send({8'd64, 23'h4},  {8'd64, 23'h5},  31'h33, 1'b0);
    send({8'd64, 23'h6},  {8'd63, 23'h7},  31'h44, 1'b0);
    idle(3);
    // Three back-to-back distinct transactions
    send(31'h40490FDB, 31'h3F000000, 31'h101, 1'b0);
    send(31'h3E800000, 31'h41200000, 31'h202, 1'b1);
    send(31'h42C80000, 31'h3DCCCCCD, 31'h303, 1'b0);
    idle(4);

    // Reset one cycle after a valid: that transaction must vanish
    send(31'h40000000, 31'h40000000, 31'h555, 1'b1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(31'h3F800000, 31'h3F800000, 31'h0, 1'b0); idle(3);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(rand_op(), rand_op(), 31'($urandom()), 1'($urandom_range(0, 1)));
      else
        idle(1);
    end
    idle(5);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
